// File: rtl/register_file_2w.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_2w
//  Description : DEPTH x DATA_W register file with two write ports (B has
//                priority), two combinational read ports, optional hardwired
//                zero entry, optional write-to-read bypass, registered
//                collision flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_2w #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WEN_A,
    input  logic [ADDR_W-1:0] RW_A,
    input  logic [DATA_W-1:0] busW_A,
    input  logic              WEN_B,
    input  logic [ADDR_W-1:0] RW_B,
    input  logic [DATA_W-1:0] busW_B,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busX,
    output logic [DATA_W-1:0] busY,
    output logic              Collide
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_zero_addr = '0;

    logic [DATA_W-1:0] w_mem [DEPTH];
    logic              w_zero_en;
    logic              w_collide_next;
    logic              r_collide;

    assign w_zero_en = (ZERO_REG != 0);

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_entry
            if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
                assign w_mem[i] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] r_q;
                // Port B is tested first so it wins a same-address write.
                always_ff @(posedge Clk) begin
                    if (Rst) begin
                        r_q <= '0;
                    end else if (WEN_B && (RW_B == ADDR_W'(i))) begin
                        r_q <= busW_B;
                    end else if (WEN_A && (RW_A == ADDR_W'(i))) begin
                        r_q <= busW_A;
                    end
                end
                assign w_mem[i] = r_q;
            end
        end
    endgenerate

    // Zero-register check precedes bypass so address 0 never forwards.
    always_comb begin
        busX = w_mem[RX];
        if (Rst) begin
            busX = '0;
        end else if (w_zero_en && (RX == c_zero_addr)) begin
            busX = '0;
        end else if ((BYPASS != 0) && WEN_B && (RW_B == RX)) begin
            busX = busW_B;
        end else if ((BYPASS != 0) && WEN_A && (RW_A == RX)) begin
            busX = busW_A;
        end
    end

    always_comb begin
        busY = w_mem[RY];
        if (Rst) begin
            busY = '0;
        end else if (w_zero_en && (RY == c_zero_addr)) begin
            busY = '0;
        end else if ((BYPASS != 0) && WEN_B && (RW_B == RY)) begin
            busY = busW_B;
        end else if ((BYPASS != 0) && WEN_A && (RW_A == RY)) begin
            busY = busW_A;
        end
    end

    assign w_collide_next = WEN_A && WEN_B && (RW_A == RW_B) &&
                            !(w_zero_en && (RW_A == c_zero_addr));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_collide <= 1'b0;
        end else begin
            r_collide <= w_collide_next;
        end
    end

    assign Collide = r_collide;

endmodule
`default_nettype wire

// File: tb/tb_register_file_2w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_2w
//  Description : Bench for register_file_2w: default, no-bypass and wide
//                (16b x 32, no zero register) instances against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_2w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 8-bit instances
    logic       rst = 1'b1;
    logic       wen_a = 1'b0, wen_b = 1'b0;
    logic [2:0] rw_a = '0, rw_b = '0, rx = '0, ry = '0;
    logic [7:0] bw_a = '0, bw_b = '0;
    logic [7:0] bx, by, bx_nb, by_nb;
    logic       col, col_nb;

    // Wide instance stimulus
    logic        wwen_a = 1'b0, wwen_b = 1'b0;
    logic [4:0]  wrw_a = '0, wrw_b = '0, wrx = '0, wry = '0;
    logic [15:0] wbw_a = '0, wbw_b = '0;
    logic [15:0] wbx, wby;
    logic        wcol;

    register_file_2w dut (
        .Clk(clk), .Rst(rst), .WEN_A(wen_a), .RW_A(rw_a), .busW_A(bw_a),
        .WEN_B(wen_b), .RW_B(rw_b), .busW_B(bw_b), .RX(rx), .RY(ry),
        .busX(bx), .busY(by), .Collide(col));

    register_file_2w #(.BYPASS(0)) dut_nb (
        .Clk(clk), .Rst(rst), .WEN_A(wen_a), .RW_A(rw_a), .busW_A(bw_a),
        .WEN_B(wen_b), .RW_B(rw_b), .busW_B(bw_b), .RX(rx), .RY(ry),
        .busX(bx_nb), .busY(by_nb), .Collide(col_nb));

    register_file_2w #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(0)) dut_w (
        .Clk(clk), .Rst(rst), .WEN_A(wwen_a), .RW_A(wrw_a), .busW_A(wbw_a),
        .WEN_B(wwen_b), .RW_B(wrw_b), .busW_B(wbw_b), .RX(wrx), .RY(wry),
        .busX(wbx), .busY(wby), .Collide(wcol));

    // Reference model: plain arrays plus the collision flag
    logic [7:0]  m8 [8];
    logic [15:0] m16 [32];
    logic        mcol, mwcol;
    int          n_pass = 0, n_total = 0;

    function automatic logic [7:0] exp8(input logic [2:0] a, input bit byp);
        if (rst || a == 3'd0) return 8'h00;
        if (byp && wen_b && rw_b == a) return bw_b;
        if (byp && wen_a && rw_a == a) return bw_a;
        return m8[a];
    endfunction

    function automatic logic [15:0] exp16(input logic [4:0] a);
        if (rst) return 16'h0000;
        if (wwen_b && wrw_b == a) return wbw_b;
        if (wwen_a && wrw_a == a) return wbw_a;
        return m16[a];
    endfunction

    // Advance one clock, updating the model from the inputs present at the edge
    task automatic step();
        if (rst) begin
            foreach (m8[k]) m8[k] = '0;
            foreach (m16[k]) m16[k] = '0;
            mcol = 1'b0;
            mwcol = 1'b0;
        end else begin
            mcol = wen_a && wen_b && (rw_a == rw_b) && (rw_a != 3'd0);
            if (wen_a && rw_a != 3'd0) m8[rw_a] = bw_a;
            if (wen_b && rw_b != 3'd0) m8[rw_b] = bw_b;
            mwcol = wwen_a && wwen_b && (wrw_a == wrw_b);
            if (wwen_a) m16[wrw_a] = wbw_a;
            if (wwen_b) m16[wrw_b] = wbw_b;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen_a = 0; wen_b = 0; wwen_a = 0; wwen_b = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wen_a = 1; rw_a = 3'(i); bw_a = 8'hAA;
            step();
        end
        idle();
        rst = 1'b1; wen_a = 1; rw_a = 3'd3; bw_a = 8'h55; rx = 3'd3; ry = 3'd5;
        #1;
        n_total++;
        if (bx !== 8'h00 || by !== 8'h00) $display("FAIL reset_read_forced bx=%h by=%h required 00", bx, by);
        else n_pass++;
        step();
        rst = 1'b0; idle();
        for (int i = 0; i < 8; i++) begin
            rx = 3'(i); ry = 3'(7 - i);
            #1;
            n_total++;
            if (bx !== 8'h00 || by !== 8'h00 || bx_nb !== 8'h00)
                $display("FAIL reset_clear addr=%0d bx=%h by=%h bx_nb=%h required 00", i, bx, by, bx_nb);
            else n_pass++;
        end
        n_total++;
        if (col !== 1'b0) $display("FAIL reset_collide col=%b required 0", col);
        else n_pass++;
    endtask

    task automatic test_dual_write();
        wen_a = 1; rw_a = 3'd3; bw_a = 8'h11;
        wen_b = 1; rw_b = 3'd5; bw_b = 8'h22;
        step();
        idle(); rx = 3'd3; ry = 3'd5;
        #1;
        n_total++;
        if (bx !== 8'h11 || by !== 8'h22) $display("FAIL dual_write bx=%h by=%h required 11 22", bx, by);
        else n_pass++;
        n_total++;
        if (col !== 1'b0) $display("FAIL dual_write_collide col=%b required 0", col);
        else n_pass++;
    endtask

    task automatic test_collision();
        wen_a = 1; rw_a = 3'd2; bw_a = 8'h33;
        wen_b = 1; rw_b = 3'd2; bw_b = 8'h44;
        step();
        idle(); rx = 3'd2; ry = 3'd2;
        #1;
        n_total++;
        if (bx !== 8'h44 || by !== 8'h44 || bx_nb !== 8'h44)
            $display("FAIL collision_data bx=%h by=%h bx_nb=%h required 44", bx, by, bx_nb);
        else n_pass++;
        n_total++;
        if (col !== 1'b1 || col_nb !== 1'b1) $display("FAIL collision_flag col=%b col_nb=%b required 1", col, col_nb);
        else n_pass++;
        step();
        n_total++;
        if (col !== 1'b0) $display("FAIL collision_pulse col=%b required 0", col);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 2; c++) begin
            wen_a = 1; rw_a = 3'd6; bw_a = 8'(8'h60 + c);
            wen_b = 1; rw_b = 3'd6; bw_b = 8'(8'h70 + c);
            step();
            n_total++;
            if (col !== 1'b1) $display("FAIL back_to_back_collide cycle=%0d col=%b required 1", c, col);
            else n_pass++;
        end
        idle(); rx = 3'd6;
        #1;
        n_total++;
        if (bx !== 8'h71) $display("FAIL back_to_back_data bx=%h required 71", bx);
        else n_pass++;
        step();
    endtask

    task automatic test_bypass();
        wen_a = 1; rw_a = 3'd4; bw_a = 8'h01;
        step();
        idle();
        wen_b = 1; rw_b = 3'd4; bw_b = 8'h7F;
        wen_a = 1; rw_a = 3'd1; bw_a = 8'h9C;
        rx = 3'd4; ry = 3'd1;
        #1;
        n_total++;
        if (bx !== 8'h7F || by !== 8'h9C) $display("FAIL bypass_on bx=%h by=%h required 7f 9c", bx, by);
        else n_pass++;
        n_total++;
        if (bx_nb !== 8'h01 || by_nb !== m8[1]) $display("FAIL bypass_off bx=%h by=%h required 01 %h", bx_nb, by_nb, m8[1]);
        else n_pass++;
        step();
        idle();
        #1;
        n_total++;
        if (bx_nb !== 8'h7F || by_nb !== 8'h9C) $display("FAIL bypass_after bx=%h by=%h required 7f 9c", bx_nb, by_nb);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        wen_a = 1; rw_a = 3'd0; bw_a = 8'hFF;
        wen_b = 1; rw_b = 3'd0; bw_b = 8'hFF;
        rx = 3'd0; ry = 3'd0;
        #1;
        n_total++;
        if (bx !== 8'h00 || by !== 8'h00) $display("FAIL zero_same_cycle bx=%h by=%h required 00", bx, by);
        else n_pass++;
        step();
        idle();
        #1;
        n_total++;
        if (bx !== 8'h00 || bx_nb !== 8'h00) $display("FAIL zero_after bx=%h bx_nb=%h required 00", bx, bx_nb);
        else n_pass++;
        n_total++;
        if (col !== 1'b0) $display("FAIL zero_collide col=%b required 0", col);
        else n_pass++;
    endtask

    task automatic test_wide();
        wwen_a = 1; wrw_a = 5'd0;  wbw_a = 16'hBEEF;
        wwen_b = 1; wrw_b = 5'd31; wbw_b = 16'hBEEF;
        step();
        idle(); wrx = 5'd0; wry = 5'd31;
        #1;
        n_total++;
        if (wbx !== 16'hBEEF || wby !== 16'hBEEF) $display("FAIL wide_beef x=%h y=%h required beef", wbx, wby);
        else n_pass++;
        for (int i = 0; i < 32; i += 2) begin
            wwen_a = 1; wrw_a = 5'(i);     wbw_a = 16'(32'h1 << (i % 16));
            wwen_b = 1; wrw_b = 5'(i + 1); wbw_b = ~16'(32'h1 << ((i + 1) % 16));
            step();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            wrx = 5'(i); wry = 5'(31 - i);
            #1;
            n_total++;
            if (wbx !== m16[i] || wby !== m16[31 - i])
                $display("FAIL wide_walk addr=%0d x=%h y=%h required %h %h", i, wbx, wby, m16[i], m16[31 - i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0]  e_x, e_y, e_xn, e_yn;
        logic [15:0] e_wx, e_wy;
        for (int n = 0; n < 300; n++) begin
            rst    = ($urandom_range(0, 29) == 0);
            wen_a  = 1'($urandom); wen_b = 1'($urandom);
            rw_a   = 3'($urandom); rw_b  = 3'($urandom);
            if ($urandom_range(0, 3) == 0) rw_b = rw_a;
            bw_a   = 8'($urandom); bw_b = 8'($urandom);
            rx     = ($urandom_range(0, 1) == 0) ? rw_b : 3'($urandom);
            ry     = ($urandom_range(0, 1) == 0) ? rw_a : 3'($urandom);
            wwen_a = 1'($urandom); wwen_b = 1'($urandom);
            wrw_a  = 5'($urandom); wrw_b  = 5'($urandom);
            if ($urandom_range(0, 3) == 0) wrw_b = wrw_a;
            wbw_a  = 16'($urandom); wbw_b = 16'($urandom);
            wrx    = ($urandom_range(0, 1) == 0) ? wrw_a : 5'($urandom);
            wry    = 5'($urandom);
            #1;
            e_x = exp8(rx, 1'b1); e_y = exp8(ry, 1'b1);
            e_xn = exp8(rx, 1'b0); e_yn = exp8(ry, 1'b0);
            e_wx = exp16(wrx); e_wy = exp16(wry);
            n_total++;
            if (bx !== e_x || by !== e_y || bx_nb !== e_xn || by_nb !== e_yn)
                $display("FAIL rand_read8 n=%0d got %h %h %h %h required %h %h %h %h",
                         n, bx, by, bx_nb, by_nb, e_x, e_y, e_xn, e_yn);
            else n_pass++;
            n_total++;
            if (wbx !== e_wx || wby !== e_wy)
                $display("FAIL rand_read16 n=%0d got %h %h required %h %h", n, wbx, wby, e_wx, e_wy);
            else n_pass++;
            step();
            n_total++;
            if (col !== mcol || col_nb !== mcol || wcol !== mwcol)
                $display("FAIL rand_collide n=%0d got %b %b %b required %b %b", n, col, col_nb, wcol, mcol, mwcol);
            else n_pass++;
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        foreach (m8[k]) m8[k] = '0;
        foreach (m16[k]) m16[k] = '0;
        mcol = 1'b0;
        mwcol = 1'b0;
        #2;
        test_reset();
        test_dual_write();
        test_collision();
        test_back_to_back();
        test_bypass();
        test_zero_reg();
        test_wide();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
